// File: rtl/cpu_controller.sv
// Moore control FSM and instruction decoder for the Simple RISC datapath.
// Fetches, decodes the live IRout and drives every datapath control input.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IRout,
    output logic        loadIR,
    output logic        loadPC,
    output logic        msel,
    output logic        mwrite,
    output logic        write,
    output logic [2:0]  writenum,
    output logic [2:0]  readnum,
    output logic [3:0]  vsel,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shiftinput,
    output logic [1:0]  ALUop,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] sximm5,
    output logic [15:0] sximm8,
    output logic        halted
);

    localparam logic [3:0] S_RST   = 4'd0;
    localparam logic [3:0] S_IF1   = 4'd1;
    localparam logic [3:0] S_IF2   = 4'd2;
    localparam logic [3:0] S_UPC   = 4'd3;
    localparam logic [3:0] S_DEC   = 4'd4;
    localparam logic [3:0] S_WIMM  = 4'd5;
    localparam logic [3:0] S_GETA  = 4'd6;
    localparam logic [3:0] S_GETB  = 4'd7;
    localparam logic [3:0] S_ALU   = 4'd8;
    localparam logic [3:0] S_WRC   = 4'd9;
    localparam logic [3:0] S_ADDR  = 4'd10;
    localparam logic [3:0] S_MEMRD = 4'd11;
    localparam logic [3:0] S_WRM   = 4'd12;
    localparam logic [3:0] S_MEMWR = 4'd13;
    localparam logic [3:0] S_HALT  = 4'd14;

    logic [3:0] r_state;
    logic [3:0] w_next;

    logic [2:0] w_opcode;
    logic [1:0] w_op;
    logic [4:0] w_opc;
    logic [2:0] w_rn;
    logic [2:0] w_rd;
    logic [1:0] w_sh;
    logic [2:0] w_rm;
    logic       w_is_str;
    logic       w_is_ldst;
    logic       w_is_cmp;
    logic       w_is_movr;

    assign w_opcode  = IRout[15:13];
    assign w_op      = IRout[12:11];
    assign w_opc     = IRout[15:11];
    assign w_rn      = IRout[10:8];
    assign w_rd      = IRout[7:5];
    assign w_sh      = IRout[4:3];
    assign w_rm      = IRout[2:0];
    assign w_is_str  = (w_opcode == 3'b100);
    assign w_is_ldst = (w_opcode == 3'b011) || w_is_str;
    assign w_is_cmp  = (w_opc == 5'b10101);
    assign w_is_movr = (w_opc == 5'b11000);

    assign sximm5 = {{11{IRout[4]}}, IRout[4:0]};
    assign sximm8 = {{8{IRout[7]}}, IRout[7:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_RST;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_RST;
        case (r_state)
            S_RST:   w_next = S_IF1;
            S_IF1:   w_next = S_IF2;
            S_IF2:   w_next = S_UPC;
            S_UPC:   w_next = S_DEC;
            S_DEC: begin
                case (w_opc)
                    5'b11010:                   w_next = S_WIMM;
                    5'b11000, 5'b10111:         w_next = S_GETB;
                    5'b10100, 5'b10101, 5'b10110,
                    5'b01100, 5'b10000:         w_next = S_GETA;
                    default:                    w_next = S_HALT;
                endcase
            end
            S_WIMM:  w_next = S_IF1;
            S_GETA:  w_next = w_is_ldst ? S_ADDR : S_GETB;
            S_GETB:  w_next = w_is_str ? S_MEMWR : S_ALU;
            S_ALU:   w_next = w_is_cmp ? S_IF1 : S_WRC;
            S_WRC:   w_next = S_IF1;
            // STR computes its address first, then fetches the store data into B
            S_ADDR:  w_next = w_is_str ? S_GETB : S_MEMRD;
            S_MEMRD: w_next = S_WRM;
            S_WRM:   w_next = S_IF1;
            S_MEMWR: w_next = S_IF1;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_RST;
        endcase
    end

    always_comb begin
        loadIR     = 1'b0;
        loadPC     = 1'b0;
        msel       = 1'b0;
        mwrite     = 1'b0;
        write      = 1'b0;
        writenum   = 3'd0;
        readnum    = 3'd0;
        vsel       = 4'b0000;
        asel       = 1'b0;
        bsel       = 1'b0;
        shiftinput = 2'b00;
        ALUop      = 2'b00;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        halted     = 1'b0;
        case (r_state)
            S_IF2:   loadIR = 1'b1;
            S_UPC:   loadPC = 1'b1;
            S_WIMM: begin
                writenum = w_rn;
                vsel     = 4'b0100;
                write    = 1'b1;
            end
            S_GETA: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            S_GETB: begin
                readnum = w_is_str ? w_rd : w_rm;
                loadb   = 1'b1;
            end
            S_ALU: begin
                // ALU-class op field maps directly onto ALUop; MOV reg adds B to a zeroed A
                shiftinput = w_sh;
                asel       = w_is_movr;
                ALUop      = w_is_movr ? 2'b00 : w_op;
                loadc      = !w_is_cmp;
                loads      = w_is_cmp;
            end
            S_WRC: begin
                writenum = w_rd;
                vsel     = 4'b0001;
                write    = 1'b1;
            end
            S_ADDR: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            S_MEMRD: msel = 1'b1;
            S_WRM: begin
                msel     = 1'b1;
                writenum = w_rd;
                vsel     = 4'b1000;
                write    = 1'b1;
            end
            S_MEMWR: begin
                msel   = 1'b1;
                mwrite = 1'b1;
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

endmodule
